wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers; address width log2(NREG).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports alu_valid / alu_ready, input / output, 1 / 1, ALU writeback request and its grant.
REQ-006 SHALL have ports alu_rd / alu_data, input / input, 5 / XLEN, ALU destination register and result.
REQ-007 SHALL have ports mem_valid / mem_ready, input / output, 1 / 1, load-unit writeback request and its grant.
REQ-008 SHALL have ports mem_rd / mem_data, input / input, 5 / XLEN, load destination register and data.
REQ-009 SHALL have ports issue_valid / issue_rd, input / input, 1 / 5, instruction issued that will write issue_rd.
REQ-010 SHALL have ports write_en / writereg_addr / write_data, output / output / output, 1 / 5 / XLEN, register-file write port.
REQ-011 SHALL have port busy, output, NREG, per-register pending-write scoreboard.

Function
REQ-012 SHALL transfer a request when valid and ready are both high in the same cycle; ready is combinational from valid and arbiter state.
REQ-013 SHALL require a requester to hold valid, rd and data stable until its ready is sampled high.
REQ-014 SHALL grant at most one requester per cycle; with one requester valid, that requester is granted.
REQ-015 SHALL resolve simultaneous requests round-robin: the requester not granted in the last conflict cycle wins. After reset, mem wins the first conflict.
REQ-016 SHALL update the round-robin pointer only in cycles where both requesters were valid.
REQ-017 SHALL register the granted transfer: write_en/writereg_addr/write_data assert in the cycle after the handshake. Latency is exactly 1, with one write per cycle sustained.
REQ-018 SHALL accept transfers with rd==0 (ready high) but drive write_en low for them; writereg_addr and write_data are don't-care when write_en is low.
REQ-019 SHALL set busy[issue_rd] on the cycle after issue_valid when issue_rd!=0; issue to x0 has no effect.
REQ-020 SHALL clear busy[r] in the same edge on which write_en asserts for address r.
REQ-021 SHALL, when a set and a clear target the same register on the same edge, leave the bit set (set wins).
REQ-022 SHALL hold busy[0] at 0 permanently.
REQ-023 SHALL leave busy[r] unchanged if a write arrives for a non-busy register; the write still proceeds.

Reset
REQ-024 SHALL drive write_en=0, writereg_addr=0, write_data=0, busy=0 and the round-robin pointer to mem-priority while rst is high, independent of clk.
REQ-025 SHALL keep alu_ready=0 and mem_ready=0 while rst is high.
REQ-026 SHALL discard any transfer whose handshake coincides with assertion of rst, and any in-flight registered write.

Structure
REQ-027 SHALL take XLEN, NREG and the requester index encoding (REQ_MEM=0, REQ_ALU=1) from a shared core package used by the register file and the pipeline.
REQ-028 SHALL contain one sub-module, rr_arb2: a 2-input round-robin arbiter with a pointer register. The scoreboard and output register stay in wb_arbiter.

Verification
REQ-029 SHALL cover ALU only: alu_valid, rd=5, data=0x11 -> alu_ready same cycle; next cycle write_en=1, writereg_addr=5, write_data=0x11.
REQ-030 SHALL cover a conflict run after reset: both valid for 3 cycles, alu rd=1 and mem rd=2 -> grants mem, alu, mem; writes to 2, 1, 2 on consecutive cycles.
REQ-031 SHALL cover the scoreboard: issue rd=7 -> busy[7]=1 next cycle; mem write rd=7 -> busy[7]=0 on the edge write_en asserts.
REQ-032 SHALL cover set/clear collision: issue rd=3 on the same edge as the write to 3 -> busy[3] remains 1.
REQ-033 SHALL cover x0: alu rd=0, data=0xFF, plus issue rd=0 -> ready=1, write_en stays 0, busy stays 0.
REQ-034 SHALL cover reset mid-operation: rst asserted between a handshake and its write cycle -> write_en=0, busy=0, and mem wins the next conflict.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared core constants (data width, register count, requester encoding)
package wb_arbiter_pkg;
    localparam int CORE_XLEN = 32;
    localparam int CORE_NREG = 32;
    localparam int REQ_MEM   = 0;
    localparam int REQ_ALU   = 1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with a pointer register
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector indexed by REQ_MEM / REQ_ALU
//   gnt      : one-hot grant, combinational from req and the pointer; zero during reset
module rr_arb2
    import wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // index of the requester that wins the next conflict
    logic prio;

    always_comb gnt = rst ? 2'b00 : (&req) ? (2'b01 << prio) : req;

    // the pointer only moves on conflicts, handing priority to the loser
    always_ff @(posedge clk or posedge rst)
        if (rst) prio <= 1'(REQ_MEM);
        else if (&req) prio <= ~prio;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter between ALU and load unit, with pending-write scoreboard
//   clk, rst                     : clock, asynchronous active-high reset
//   alu_valid/alu_ready/rd/data  : ALU writeback request and grant
//   mem_valid/mem_ready/rd/data  : load-unit writeback request and grant
//   issue_valid/issue_rd         : issued instruction that will write issue_rd
//   write_en/writereg_addr/data  : registered register-file write port (1-cycle latency)
//   busy                         : per-register pending-write scoreboard
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN = CORE_XLEN,
    parameter int NREG = CORE_NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            write_en,
    output logic [4:0]      writereg_addr,
    output logic [XLEN-1:0] write_data,
    output logic [NREG-1:0] busy
);
    logic [1:0]      req, gnt;
    logic            xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [NREG-1:0] set_mask, clr_mask, busy_next;

    always_comb begin
        req[REQ_MEM] = mem_valid;
        req[REQ_ALU] = alu_valid;
    end

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign mem_ready = gnt[REQ_MEM];
    assign xfer      = |gnt;
    assign sel_rd    = gnt[REQ_ALU] ? alu_rd : mem_rd;
    assign sel_data  = gnt[REQ_ALU] ? alu_data : mem_data;

    // clear targets the register whose write asserts on this edge; set is applied last so it wins
    always_comb begin
        set_mask  = (issue_valid && issue_rd != 5'd0) ? (NREG'(1) << issue_rd) : '0;
        clr_mask  = (xfer && sel_rd != 5'd0) ? (NREG'(1) << sel_rd) : '0;
        busy_next = (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            write_en      <= 1'b0;
            writereg_addr <= '0;
            write_data    <= '0;
            busy          <= '0;
        end else begin
            write_en      <= xfer && sel_rd != 5'd0;
            writereg_addr <= sel_rd;
            write_data    <= sel_data;
            busy          <= busy_next;
        end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed table-driven bench for wb_arbiter
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
    logic        alu_ready, mem_ready, write_en;
    logic [4:0]  alu_rd = '0, mem_rd = '0, issue_rd = '0, writereg_addr;
    logic [31:0] alu_data = '0, mem_data = '0, write_data, busy;

    int n_cmp = 0;
    int n_fail = 0;

    wb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .write_en      (write_en),
        .writereg_addr (writereg_addr),
        .write_data    (write_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        iv;
        logic [4:0]  ird;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         input logic iv, input logic [4:0] ird);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
        issue_valid = iv; issue_rd = ird;
    endtask

    initial begin
        //            av ard  adat    mv mrd mdat    iv ird  ar mr we addr data    busy
        vecs[0]  = '{1, 5, 32'h11, 0, 0, 32'h0,  0, 0,  1, 0, 1, 5,  32'h11, 32'h0};
        vecs[1]  = '{1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0,  0, 1, 1, 2,  32'hB2, 32'h0};
        vecs[2]  = '{1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0,  1, 0, 1, 1,  32'hA1, 32'h0};
        vecs[3]  = '{1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0,  0, 1, 1, 2,  32'hB2, 32'h0};
        vecs[4]  = '{0, 0, 32'h0,  0, 0, 32'h0,  0, 0,  0, 0, 0, 0,  32'h0,  32'h0};
        vecs[5]  = '{0, 0, 32'h0,  0, 0, 32'h0,  1, 7,  0, 0, 0, 0,  32'h0,  32'h80};
        vecs[6]  = '{0, 0, 32'h0,  1, 7, 32'h77, 0, 0,  0, 1, 1, 7,  32'h77, 32'h0};
        vecs[7]  = '{0, 0, 32'h0,  0, 0, 32'h0,  1, 3,  0, 0, 0, 0,  32'h0,  32'h8};
        vecs[8]  = '{1, 3, 32'h33, 0, 0, 32'h0,  1, 3,  1, 0, 1, 3,  32'h33, 32'h8};
        vecs[9]  = '{1, 0, 32'hFF, 0, 0, 32'h0,  1, 0,  1, 0, 0, 0,  32'h0,  32'h8};
        vecs[10] = '{0, 0, 32'h0,  1, 3, 32'h3,  0, 0,  0, 1, 1, 3,  32'h3,  32'h0};
        vecs[11] = '{0, 0, 32'h0,  1, 9, 32'h99, 0, 0,  0, 1, 1, 9,  32'h99, 32'h0};
        vecs[12] = '{1, 4, 32'h44, 1, 6, 32'h66, 0, 0,  1, 0, 1, 4,  32'h44, 32'h0};
        vecs[13] = '{1, 4, 32'h44, 1, 6, 32'h66, 0, 0,  0, 1, 1, 6,  32'h66, 32'h0};
        vecs[14] = '{1, 11, 32'hBB, 0, 0, 32'h0, 1, 10, 1, 0, 1, 11, 32'hBB, 32'h400};

        // reset state, checked before any clock edge with both requesters asking
        #1 rst = 1'b1;
        drive(1, 5, 32'h55, 1, 6, 32'h66, 1, 4);
        #2;
        check("rst_write_en", 32'(write_en), 32'h0);
        check("rst_addr", 32'(writereg_addr), 32'h0);
        check("rst_data", write_data, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_alu_ready", 32'(alu_ready), 32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd,
                  vecs[i].mdat, vecs[i].iv, vecs[i].ird);
            #1;
            check($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
            check($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_write_en", i), 32'(write_en), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                check($sformatf("v%0d_addr", i), 32'(writereg_addr), 32'(vecs[i].e_addr));
                check($sformatf("v%0d_data", i), write_data, vecs[i].e_data);
            end
            check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            @(negedge clk);
        end

        // reset lands after a handshake and before its write is consumed; pointer currently favours alu
        drive(1, 1, 32'hA1, 1, 2, 32'hB2, 1, 12);
        #1;
        check("mid_alu_ready", 32'(alu_ready), 32'h1);
        check("mid_mem_ready", 32'(mem_ready), 32'h0);
        @(posedge clk);
        #1;
        check("mid_write_en", 32'(write_en), 32'h1);
        check("mid_addr", 32'(writereg_addr), 32'h1);
        check("mid_busy", busy, 32'h1400);
        rst = 1'b1;
        #1;
        check("mid_rst_write_en", 32'(write_en), 32'h0);
        check("mid_rst_addr", 32'(writereg_addr), 32'h0);
        check("mid_rst_data", write_data, 32'h0);
        check("mid_rst_busy", busy, 32'h0);
        check("mid_rst_alu_ready", 32'(alu_ready), 32'h0);
        check("mid_rst_mem_ready", 32'(mem_ready), 32'h0);
        @(posedge clk);
        #1;
        check("rst_edge_write_en", 32'(write_en), 32'h0);
        check("rst_edge_busy", busy, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        issue_valid = 1'b0;
        #1;
        check("post_rst_mem_ready", 32'(mem_ready), 32'h1);
        check("post_rst_alu_ready", 32'(alu_ready), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_write_en", 32'(write_en), 32'h1);
        check("post_rst_addr", 32'(writereg_addr), 32'h2);
        check("post_rst_data", write_data, 32'hB2);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("idle_write_en", 32'(write_en), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
